// File: rtl/mips_id_stage_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared MIPS-I decode definitions for the ID stage: opcode and funct
// constants plus small helpers that slice the standard instruction fields.
// No ports (package).
// -----------------------------------------------------------------------------
package mips_pkg;

    // Primary opcodes, instruction bits [31:26]
    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    // R-type funct codes, instruction bits [5:0]
    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_SLT  = 6'h2A;

    function automatic logic [5:0] ins_op(input logic [31:0] ins);
        return ins[31:26];
    endfunction

    function automatic logic [4:0] ins_rs(input logic [31:0] ins);
        return ins[25:21];
    endfunction

    function automatic logic [4:0] ins_rt(input logic [31:0] ins);
        return ins[20:16];
    endfunction

    function automatic logic [4:0] ins_rd(input logic [31:0] ins);
        return ins[15:11];
    endfunction

    function automatic logic [4:0] ins_shamt(input logic [31:0] ins);
        return ins[10:6];
    endfunction

    function automatic logic [5:0] ins_funct(input logic [31:0] ins);
        return ins[5:0];
    endfunction

    function automatic logic [15:0] ins_imm(input logic [31:0] ins);
        return ins[15:0];
    endfunction

endpackage

// File: rtl/mips_id_stage_if.sv
// -----------------------------------------------------------------------------
// mips_id_stage_if
// Bundles every non-clock/reset signal of the ID stage:
//   IF side  : if_valid, if_ins, if_nextpc -> ; <- id_ready
//   EX side  : ex_ready, flush -> ; <- ex_valid, Ins, Rdata1, Rdata2, Ed32, nextPC
//   Writeback: wb_we, wb_addr, wb_data ->
// master = environment (IF/EX/WB), slave = the ID stage itself.
// -----------------------------------------------------------------------------
interface mips_id_stage_if;

    logic        if_valid;
    logic [31:0] if_ins;
    logic [31:0] if_nextpc;
    logic        id_ready;
    logic        ex_ready;
    logic        flush;
    logic        ex_valid;
    logic [31:0] Ins;
    logic [31:0] Rdata1;
    logic [31:0] Rdata2;
    logic [31:0] Ed32;
    logic [31:0] nextPC;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    modport master (
        output if_valid, if_ins, if_nextpc, ex_ready, flush, wb_we, wb_addr, wb_data,
        input  id_ready, ex_valid, Ins, Rdata1, Rdata2, Ed32, nextPC
    );

    modport slave (
        input  if_valid, if_ins, if_nextpc, ex_ready, flush, wb_we, wb_addr, wb_data,
        output id_ready, ex_valid, Ins, Rdata1, Rdata2, Ed32, nextPC
    );

endinterface

// File: rtl/mips_id_stage_regfile.sv
// -----------------------------------------------------------------------------
// mips_regfile
// 32 x 32 general-purpose register file, two combinational read ports and one
// synchronous write port. GPR0 is hard zero. With WB_BYPASS=1 a write in the
// same cycle as a read of the same (non-zero) register returns the new data.
// Ports:
//   CLK, RST            clock, async active-high reset (clears all GPRs)
//   i_we/i_waddr/i_wdata write port
//   i_raddr1/i_raddr2   read addresses
//   o_rdata1/o_rdata2   read data
// -----------------------------------------------------------------------------
module mips_regfile #(
    parameter int DATA_W    = 32,
    parameter int REG_AW    = 5,
    parameter int WB_BYPASS = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [REG_AW-1:0] i_raddr1,
    input  logic [REG_AW-1:0] i_raddr2,
    output logic [DATA_W-1:0] o_rdata1,
    output logic [DATA_W-1:0] o_rdata2
);

    localparam int NREGS = 1 << REG_AW;

    logic [DATA_W-1:0] r_gpr [0:NREGS-1];
    logic              w_wr_ok;
    logic              w_hit1;
    logic              w_hit2;

    assign w_wr_ok = i_we && (i_waddr != {REG_AW{1'b0}});
    assign w_hit1  = (WB_BYPASS != 0) && w_wr_ok && (i_waddr == i_raddr1);
    assign w_hit2  = (WB_BYPASS != 0) && w_wr_ok && (i_waddr == i_raddr2);

    // Register storage: cleared on reset, GPR0 never written
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NREGS; i++) begin
                r_gpr[i] <= {DATA_W{1'b0}};
            end
        end else if (w_wr_ok) begin
            r_gpr[i_waddr] <= i_wdata;
        end
    end

    // Read port 1 with zero register and optional writeback forwarding
    always_comb begin
        o_rdata1 = {DATA_W{1'b0}};
        if (i_raddr1 == {REG_AW{1'b0}}) begin
            o_rdata1 = {DATA_W{1'b0}};
        end else if (w_hit1) begin
            o_rdata1 = i_wdata;
        end else begin
            o_rdata1 = r_gpr[i_raddr1];
        end
    end

    // Read port 2 with zero register and optional writeback forwarding
    always_comb begin
        o_rdata2 = {DATA_W{1'b0}};
        if (i_raddr2 == {REG_AW{1'b0}}) begin
            o_rdata2 = {DATA_W{1'b0}};
        end else if (w_hit2) begin
            o_rdata2 = i_wdata;
        end else begin
            o_rdata2 = r_gpr[i_raddr2];
        end
    end

endmodule

// File: rtl/mips_id_stage.sv
// -----------------------------------------------------------------------------
// mips_id_stage
// MIPS-I instruction decode stage. Reads rs/rt from the register file,
// builds the extended immediate in the form EX expects, and registers the
// operand bundle into the ID/EX pipeline register under a valid/ready
// handshake with one-cycle load-use bubbles and branch flush.
// Ports:
//   CLK  rising-edge clock
//   RST  asynchronous active-high reset
//   bus  mips_id_stage_if.slave (IF handshake, EX bundle, writeback port)
// -----------------------------------------------------------------------------
module mips_id_stage
    import mips_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int REG_AW    = 5,
    parameter int WB_BYPASS = 1
) (
    input  logic           CLK,
    input  logic           RST,
    mips_id_stage_if.slave bus
);

    logic [4:0]        w_rs;
    logic [4:0]        w_rt;
    logic [5:0]        w_op;
    logic [5:0]        w_funct;
    logic [DATA_W-1:0] w_rdata1;
    logic [DATA_W-1:0] w_rdata2;
    logic [31:0]       w_ed32;
    logic              w_adv;
    logic              w_haz;
    logic [4:0]        w_ld_rt;

    logic              r_ex_valid;
    logic [31:0]       r_ins;
    logic [DATA_W-1:0] r_rdata1;
    logic [DATA_W-1:0] r_rdata2;
    logic [31:0]       r_ed32;
    logic [31:0]       r_nextpc;

    assign w_rs    = ins_rs(bus.if_ins);
    assign w_rt    = ins_rt(bus.if_ins);
    assign w_op    = ins_op(bus.if_ins);
    assign w_funct = ins_funct(bus.if_ins);

    mips_regfile #(
        .DATA_W    (DATA_W),
        .REG_AW    (REG_AW),
        .WB_BYPASS (WB_BYPASS)
    ) u_regfile (
        .CLK      (CLK),
        .RST      (RST),
        .i_we     (bus.wb_we),
        .i_waddr  (bus.wb_addr),
        .i_wdata  (bus.wb_data),
        .i_raddr1 (w_rs),
        .i_raddr2 (w_rt),
        .o_rdata1 (w_rdata1),
        .o_rdata2 (w_rdata2)
    );

    // The bundle may move on when the slot is empty or EX takes it now.
    // A load in EX whose target is a source of the IF instruction forces a
    // bubble; the comparison is on field positions only, regardless of
    // whether the instruction actually uses rs/rt.
    assign w_ld_rt = ins_rt(r_ins);
    assign w_adv   = !r_ex_valid || bus.ex_ready;
    assign w_haz   = r_ex_valid && (ins_op(r_ins) == OP_LW) && (w_ld_rt != 5'd0) &&
                     ((w_ld_rt == w_rs) || (w_ld_rt == w_rt));

    // Flush always lets IF drop its instruction, so ready is forced high
    assign bus.id_ready = bus.flush || (w_adv && !w_haz);

    // Extended immediate selection; branches stay unshifted for EX
    always_comb begin
        w_ed32 = 32'd0;
        case (w_op)
            OP_RTYPE: begin
                case (w_funct)
                    F_SLL, F_SRL, F_SRA: w_ed32 = {27'd0, ins_shamt(bus.if_ins)};
                    default:             w_ed32 = 32'd0;
                endcase
            end
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: w_ed32 = {16'd0, ins_imm(bus.if_ins)};
            OP_J, OP_JAL: w_ed32 = {bus.if_nextpc[31:28], bus.if_ins[25:0], 2'b00};
            default:      w_ed32 = {{16{bus.if_ins[15]}}, ins_imm(bus.if_ins)};
        endcase
    end

    // ID/EX pipeline register: flush > bubble > load > drain > hold
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ex_valid <= 1'b0;
            r_ins      <= 32'd0;
            r_rdata1   <= {DATA_W{1'b0}};
            r_rdata2   <= {DATA_W{1'b0}};
            r_ed32     <= 32'd0;
            r_nextpc   <= 32'd0;
        end else if (bus.flush) begin
            r_ex_valid <= 1'b0;
        end else if (w_adv && w_haz) begin
            r_ex_valid <= 1'b0;
        end else if (w_adv && bus.if_valid) begin
            r_ex_valid <= 1'b1;
            r_ins      <= bus.if_ins;
            r_rdata1   <= w_rdata1;
            r_rdata2   <= w_rdata2;
            r_ed32     <= w_ed32;
            r_nextpc   <= bus.if_nextpc;
        end else if (w_adv) begin
            r_ex_valid <= 1'b0;
        end
    end

    assign bus.ex_valid = r_ex_valid;
    assign bus.Ins      = r_ins;
    assign bus.Rdata1   = r_rdata1;
    assign bus.Rdata2   = r_rdata2;
    assign bus.Ed32     = r_ed32;
    assign bus.nextPC   = r_nextpc;

endmodule

// File: tb/tb_mips_id_stage.sv
// -----------------------------------------------------------------------------
// tb_mips_id_stage
// Scoreboard bench for mips_id_stage: a transaction-level model decides which
// instructions are issued and what bundle each must produce; a monitor pops
// and compares each bundle when EX takes it or it is flushed.
// -----------------------------------------------------------------------------
module tb_mips_id_stage;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] ed;
        logic [31:0] npc;
    } bundle_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mips_id_stage_if bus();

    mips_id_stage #(.DATA_W(32), .REG_AW(5), .WB_BYPASS(1)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bundle_t     sb_q[$];
    logic [31:0] m_gpr [32];
    logic [31:0] m_ins;
    logic        m_valid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_ext(input logic [31:0] ins, input logic [31:0] npc);
        int unsigned op, fn, imm;
        op  = ins >> 26;
        fn  = ins & 32'h3F;
        imm = ins & 32'hFFFF;
        if (op == 0)
            return (fn == 0 || fn == 2 || fn == 3) ? ((ins >> 6) & 32'h1F) : 32'd0;
        if (op >= 32'hC && op <= 32'hF)
            return imm;
        if (op == 2 || op == 3)
            return (npc & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
        return (imm >= 32'h8000) ? (imm | 32'hFFFF_0000) : imm;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
        if (we && wa == a) return wd;
        return m_gpr[a];
    endfunction

    // One pipeline cycle: drive inputs, check what is visible now, advance model
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] npc,
                         input logic rdy, input logic fl, input logic we,
                         input logic [4:0] wa, input logic [31:0] wd);
        logic [4:0] rs, rt, ldrt;
        logic       haz, adv, exp_rdy;
        bundle_t    b;
        @(negedge clk);
        bus.if_valid = v;  bus.if_ins = ins; bus.if_nextpc = npc;
        bus.ex_ready = rdy; bus.flush = fl;
        bus.wb_we = we; bus.wb_addr = wa; bus.wb_data = wd;
        #1;
        rs   = ins[25:21];
        rt   = ins[20:16];
        ldrt = m_ins[20:16];
        haz  = m_valid && (m_ins[31:26] == 6'h23) && (ldrt != 5'd0) && (ldrt == rs || ldrt == rt);
        adv  = !m_valid || rdy;
        exp_rdy = fl || (adv && !haz);
        chk("id_ready", {31'd0, bus.id_ready}, {31'd0, exp_rdy});
        chk("ex_valid", {31'd0, bus.ex_valid}, {31'd0, m_valid});
        if (fl) begin
            m_valid = 1'b0;
        end else if (adv && haz) begin
            m_valid = 1'b0;
        end else if (adv && v) begin
            b.ins = ins;
            b.r1  = m_read(rs, we, wa, wd);
            b.r2  = m_read(rt, we, wa, wd);
            b.ed  = m_ext(ins, npc);
            b.npc = npc;
            sb_q.push_back(b);
            m_ins   = ins;
            m_valid = 1'b1;
        end else if (adv) begin
            m_valid = 1'b0;
        end
        if (we && wa != 5'd0) m_gpr[wa] = wd;
    endtask

    function automatic logic [31:0] rand_ins();
        logic [4:0]  rs, rt, rd, sh;
        logic [15:0] imm;
        logic [25:0] tgt;
        rs  = 5'($urandom_range(0, 3));
        rt  = 5'($urandom_range(0, 3));
        rd  = 5'($urandom_range(0, 3));
        sh  = 5'($urandom);
        imm = 16'($urandom);
        tgt = 26'($urandom);
        case ($urandom_range(0, 11))
            0:  return {6'h00, rs, rt, rd, 5'd0, 6'h20};
            1:  return {6'h00, 5'd0, rt, rd, sh, 6'h00};
            2:  return {6'h00, 5'd0, rt, rd, sh, 6'h03};
            3:  return {6'h08, rs, rt, imm};
            4:  return {6'h0D, rs, rt, imm};
            5:  return {6'h0F, 5'd0, rt, imm};
            6:  return {6'h02, tgt};
            7:  return {6'h03, tgt};
            8:  return {6'h04, rs, rt, imm};
            9:  return {6'h2B, rs, rt, imm};
            10: return {6'h00, rs, rt, rd, sh, 6'h02};
            default: return {6'h23, rs, rt, imm};
        endcase
    endfunction

    task automatic rand_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            cycle($urandom_range(0, 9) < 8, rand_ins(), $urandom & 32'hFFFF_FFFC,
                  $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)), $urandom);
        end
    endtask

    // Monitor: each presented bundle ends when EX takes it or a flush kills it
    initial begin
        bundle_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && bus.ex_valid && (bus.ex_ready || bus.flush)) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_bundle", bus.Ins, 32'hXXXX_XXXX);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_Ins",    bus.Ins,    e.ins);
                    chk("sb_Rdata1", bus.Rdata1, e.r1);
                    chk("sb_Rdata2", bus.Rdata2, e.r2);
                    chk("sb_Ed32",   bus.Ed32,   e.ed);
                    chk("sb_nextPC", bus.nextPC, e.npc);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
        m_ins = 32'd0;
        m_valid = 1'b0;
        bus.if_valid = 1'b1; bus.if_ins = 32'h0022_1820; bus.if_nextpc = 32'h0000_0004;
        bus.ex_ready = 1'b1; bus.flush = 1'b0;
        bus.wb_we = 1'b0; bus.wb_addr = 5'd0; bus.wb_data = 32'd0;

        // Reset held three cycles with IF offering an instruction
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("rst_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
            chk("rst_Ins",      bus.Ins,    32'd0);
            chk("rst_Rdata1",   bus.Rdata1, 32'd0);
            chk("rst_Rdata2",   bus.Rdata2, 32'd0);
            chk("rst_Ed32",     bus.Ed32,   32'd0);
            chk("rst_nextPC",   bus.nextPC, 32'd0);
        end
        bus.if_valid = 1'b0;
        rst = 1'b0;

        // Directed: empty regfile, writebacks, $0, immediates, bypass
        cycle(1'b1, 32'h0022_1820, 32'h0000_0100, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd1, 32'd5);
        chk("empty_Rdata1", bus.Rdata1, 32'd0);
        chk("empty_Rdata2", bus.Rdata2, 32'd0);
        cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd2, 32'd3);
        cycle(1'b1, 32'h0022_1820, 32'h0000_0204, 1'b1, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        cycle(1'b1, 32'h2021_FFFE, 32'h0000_0208, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("add_Rdata1", bus.Rdata1, 32'd5);
        chk("add_Rdata2", bus.Rdata2, 32'd3);
        chk("add_Ed32",   bus.Ed32,   32'd0);
        chk("add_nextPC", bus.nextPC, 32'h0000_0204);
        cycle(1'b1, 32'h3421_FFFE, 32'h0000_020C, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("addi_Ed32", bus.Ed32, 32'hFFFF_FFFE);
        cycle(1'b1, 32'h0001_0880, 32'h0000_0210, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("ori_Ed32", bus.Ed32, 32'h0000_FFFE);
        cycle(1'b1, 32'h0800_0400, 32'h0000_0004, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("sll_Ed32", bus.Ed32, 32'h0000_0002);
        cycle(1'b1, 32'h1000_0002, 32'h0000_0008, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("j_Ed32", bus.Ed32, 32'h0000_1000);
        cycle(1'b1, 32'h0000_1820, 32'h0000_000C, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("beq_Ed32", bus.Ed32, 32'h0000_0002);
        cycle(1'b1, 32'h0022_1820, 32'h0000_0010, 1'b1, 1'b0, 1'b1, 5'd1, 32'hA5A5_A5A5);
        chk("r0_Rdata1", bus.Rdata1, 32'd0);
        chk("r0_Rdata2", bus.Rdata2, 32'd0);

        // Load-use: LW $2 then ADD $3,$2,$3 -> one bubble
        cycle(1'b1, 32'h8C22_0004, 32'h0000_0014, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("bypass_Rdata1", bus.Rdata1, 32'hA5A5_A5A5);
        cycle(1'b1, 32'h0043_1820, 32'h0000_0018, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("lu_id_ready", {31'd0, bus.id_ready}, 32'd0);
        cycle(1'b1, 32'h0043_1820, 32'h0000_0018, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("lu_bubble_valid", {31'd0, bus.ex_valid}, 32'd0);

        // Backpressure for three cycles, then a flush with IF offering
        cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("bp_Ins", bus.Ins, 32'h0043_1820);
        cycle(1'b1, 32'h2002_0007, 32'h0000_001C, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        cycle(1'b1, 32'h2002_0007, 32'h0000_001C, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("bp_hold_Ins", bus.Ins, 32'h0043_1820);
        chk("bp_hold_ready", {31'd0, bus.id_ready}, 32'd0);
        cycle(1'b1, 32'h2002_0007, 32'h0000_001C, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
        cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("flush_valid", {31'd0, bus.ex_valid}, 32'd0);

        rand_cycles(600);

        // Reset asserted while a bundle is stalled
        cycle(1'b1, 32'h0022_1820, 32'h0000_0040, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        rst = 1'b1;
        sb_q.delete();
        m_valid = 1'b0;
        m_ins = 32'd0;
        for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
        #1;
        chk("midrst_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("midrst_Ins",      bus.Ins,    32'd0);
        chk("midrst_Rdata1",   bus.Rdata1, 32'd0);
        chk("midrst_nextPC",   bus.nextPC, 32'd0);
        bus.if_valid = 1'b0; bus.flush = 1'b0; bus.wb_we = 1'b0; bus.ex_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        rand_cycles(300);

        repeat (3) cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_id_stage.md
Name: mips_id_stage

Overview:
Instruction-decode stage that produces the operand bundle (Ins, Rdata1, Rdata2, Ed32, nextPC) consumed by the EX stage.
- Holds the 32x32 register file with a writeback port.
- Generates the extended immediate in the exact form EX expects.
- Registers the bundle into the ID/EX pipeline register with a valid/ready handshake, load-use stall and branch flush.

Parameters:
DATA_W, 32, datapath width (fixed at 32 for MIPS-I; parameter exists for lint only)
REG_AW, 5, register address width (32 registers)
WB_BYPASS, 1, 1 = same-cycle writeback data is forwarded into the read ports

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous, active-high reset
if_valid  in  1  IF presents an instruction
if_ins  in  32  instruction word
if_nextpc  in  32  PC+4 of that instruction
id_ready  out  1  ID accepts if_ins this cycle (combinational)
ex_ready  in  1  EX consumes the current bundle this cycle
flush  in  1  EX resolved a taken branch/jump; squash ID contents
ex_valid  out  1  bundle below is valid
Ins  out  32  registered instruction
Rdata1  out  32  registered GPR[rs]
Rdata2  out  32  registered GPR[rt]
Ed32  out  32  registered extended immediate
nextPC  out  32  registered PC+4
wb_we  in  1  register write enable
wb_addr  in  5  write register number
wb_data  in  32  write data

Behaviour:
- Reset (async, RST=1): ex_valid=0; Ins, Rdata1, Rdata2, Ed32 and nextPC all 0; all 32 GPRs cleared to 0. State releases on the first rising CLK edge after RST falls.
- Register file: write on rising CLK when wb_we=1 and wb_addr!=0. GPR0 always reads 0; writes to it are ignored.
- Reads are combinational on rs=if_ins[25:21], rt=if_ins[20:16].
- With WB_BYPASS=1: if wb_we=1, wb_addr!=0 and wb_addr equals the read address, the read returns wb_data.
- Ed32 rules by opcode/funct:
  - R-type SLL/SRL/SRA (funct 00,02,03): zero-extended shamt [10:6].
  - ANDI/ORI/XORI/LUI (0C,0D,0E,0F): zero-extended imm16.
  - J/JAL (02,03): {if_nextpc[31:28], if_ins[25:0], 2'b00}.
  - All other I-types (ADDI/ADDIU/SLTI/SLTIU/LW/SW/branches/REGIMM): sign-extended imm16, unshifted. EX applies <<2 for branches.
  - Other R-types: 0.
- Advance condition: adv = !ex_valid || ex_ready.
- Load-use hazard: haz = ex_valid && Ins[31:26]==6'h23 && Ins[20:16]!=0 && (Ins[20:16]==rs || Ins[20:16]==rt).
- id_ready = adv && !haz.
- Per-cycle priority (highest first):
  1. flush=1: ex_valid<=0, bundle regs hold old values; id_ready forced 1 and any if_valid instruction is discarded.
  2. adv && haz: bubble; ex_valid<=0, IF instruction not accepted (id_ready=0).
  3. adv && if_valid: load bundle, ex_valid<=1.
  4. adv && !if_valid: ex_valid<=0.
  5. !adv: hold everything.
- Latency: one cycle from accepted if_ins to ex_valid.
- A hazard stalls exactly one cycle: the bubble clears ex_valid, so haz drops the next cycle.
- Held bundle is not re-read: a writeback landing during a hold does not update Rdata1/Rdata2. Stalls originate in EX, which is responsible for this case.
- Simultaneous writeback and read of the same register in the accept cycle: new data is captured when WB_BYPASS=1, old data when WB_BYPASS=0.
- RST asserted mid-stall: immediate clear; no partial bundle survives.

Decomposition:
- Package mips_pkg holds:
  - opcode constants (OP_RTYPE, OP_REGIMM, OP_J, OP_JAL, OP_BEQ..OP_LUI, OP_LW, OP_SW);
  - funct constants (F_SLL, F_SRL, F_SRA, ...);
  - field-slice helper functions rs/rt/rd/shamt/imm.
- One sub-module: mips_regfile (32x32, async-reset, 2R1W, optional bypass).
- Immediate extension and hazard logic stay inline.

Test Plan:
- Reset: hold RST 3 cycles with if_valid=1 -> ex_valid=0 and all outputs 0 throughout. After release, ADD $3,$1,$2 (0x00221820) with empty regfile -> Rdata1=Rdata2=0.
- Writeback then read: wb $1=5, $2=3, then issue 0x00221820 -> next cycle ex_valid=1, Rdata1=5, Rdata2=3, Ed32=0, nextPC=if_nextpc. Write to $0 of 0xFFFFFFFF -> reading $0 returns 0.
- Immediates:
  - ADDI 0x2021FFFE -> Ed32=FFFFFFFE.
  - ORI 0x3421FFFE -> Ed32=0000FFFE.
  - SLL 0x00010880 -> Ed32=2.
  - J 0x08000400 with nextpc=0x00000004 -> Ed32=00001000.
  - BEQ 0x10000002 -> Ed32=2.
- Bypass: wb_we=1, wb_addr=1, wb_data=0xA5A5A5A5 in the same cycle ADD is accepted -> Rdata1=A5A5A5A5.
- Load-use: LW $2,4($1) (0x8C220004) accepted, then ADD using $2 -> one cycle with id_ready=0 and ex_valid=0 (bubble); ADD issues the following cycle.
- Backpressure and flush:
  - ex_ready=0 for 3 cycles -> bundle and ex_valid=1 held stable, id_ready=0.
  - flush=1 with if_valid=1 -> ex_valid=0 next cycle and the incoming instruction is never issued.
